// File: rtl/spi_pkg.sv
// spi_pkg: command encodings, frame size and controller states shared by the SPI master.
package spi_pkg;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam int FRAME_BITS = 10;
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_SHIFT, S_WAIT, S_CAPTURE, S_GAP} state_e;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: one register serves as the 10-bit TX frame and as the 8-bit MISO capture.
module spi_shift_reg
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_out_i,
  input  logic                  shift_in_i,
  input  logic                  in_bit_i,
  input  logic [FRAME_BITS-1:0] load_val_i,
  output logic                  out_bit_o,
  output logic [7:0]            in_byte_o
);
  logic [FRAME_BITS-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else if (load_i) sr_q <= load_val_i;
    else if (shift_out_i) sr_q <= {sr_q[FRAME_BITS-2:0], 1'b0};
    else if (shift_in_i) sr_q <= {sr_q[FRAME_BITS-2:0], in_bit_i};
  end
  assign out_bit_o = sr_q[FRAME_BITS-1];
  // includes the bit being sampled this cycle, so the 8th sample yields the full byte
  assign in_byte_o = {sr_q[6:0], in_bit_i};
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: turns one cmd/byte request into a framed SPI transfer and captures read-data replies.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int MISO_DELAY = 3,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_byte,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy
);
  localparam int WMAX = MISO_DELAY > GAP ? MISO_DELAY : GAP;
  localparam int CMAX = WMAX > FRAME_BITS ? WMAX : FRAME_BITS;
  localparam int CW   = $clog2(CMAX + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [7:0]    rd_data_q, rd_data_d, in_byte;
  logic          ss_n_q, ss_n_d, mosi_q, mosi_d, ready_q, ready_d;
  logic          busy_q, busy_d, rd_valid_q, rd_valid_d;
  logic          fire, last, sr_out;
  assign fire = req_valid && ready_q;
  // per-state terminal count; the counter restarts on every state change
  assign last = cnt_q == (state_q == S_SHIFT   ? CW'(FRAME_BITS - 1) :
                          state_q == S_WAIT    ? CW'(MISO_DELAY - 1) :
                          state_q == S_CAPTURE ? CW'(7) : CW'(GAP - 1));
  spi_shift_reg u_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (fire),
    .shift_out_i (state_d == S_SHIFT),
    .shift_in_i  (state_q == S_CAPTURE),
    .in_bit_i    (MISO),
    .load_val_i  ({req_cmd, req_cmd == CMD_RD_DATA ? 8'h00 : req_byte}),
    .out_bit_o   (sr_out),
    .in_byte_o   (in_byte)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = fire ? S_SEL : S_IDLE;
      S_SEL:     state_d = S_SHIFT;
      S_SHIFT:   if (last) state_d = cmd_q != CMD_RD_DATA ? S_GAP : MISO_DELAY == 0 ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (last) state_d = S_CAPTURE;
      S_CAPTURE: if (last) state_d = S_GAP;
      S_GAP:     if (last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    cnt_d      = state_d == state_q ? cnt_q + 1'b1 : '0;
    cmd_d      = fire ? req_cmd : cmd_q;
    ss_n_d     = state_d inside {S_IDLE, S_GAP};
    mosi_d     = state_d == S_SEL ? req_cmd[1] : (state_d == S_SHIFT) && sr_out;
    ready_d    = state_d == S_IDLE;
    busy_d     = state_d != S_IDLE;
    rd_valid_d = state_q == S_CAPTURE && last;
    rd_data_d  = rd_valid_d ? in_byte : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end
  assign req_ready = ready_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign busy      = busy_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: drives both delay variants against a behavioural SPI RAM slave and scoreboards frames and replies.
module tb_spi_master_ctrl;
  import spi_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [1:0] cmd = '0;
  logic [7:0] byt = '0;
  logic r1, ss1, mo1, rv1, b1, mi1 = 1'b0;
  logic r2, ss2, mo2, rv2, b2, mi2 = 1'b0;
  logic [7:0] rd1, rd2;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  spi_master_ctrl #(.MISO_DELAY(3), .GAP(1)) dut (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1), .req_cmd(cmd), .req_byte(byt),
    .SS_n(ss1), .MOSI(mo1), .MISO(mi1), .rd_data(rd1), .rd_valid(rv1), .busy(b1));
  spi_master_ctrl #(.MISO_DELAY(1), .GAP(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(r2), .req_cmd(cmd), .req_byte(byt),
    .SS_n(ss2), .MOSI(mo2), .MISO(mi2), .rd_data(rd2), .rd_valid(rv2), .busy(b2));

  // slave model for dut: decodes the 10 bits after the pre-bit, replies 3 idle cycles later
  logic [7:0] mem [0:255];
  logic [7:0] addr_m = '0, reply1 = '0, pat2 = 8'hC3;
  logic [9:0] fr1 = '0;
  int lc1 = 0, lc2 = 0, rv_cnt = 0;
  bit fixed = 0;
  always @(negedge clk) begin
    if (ss1 !== 1'b0) begin
      lc1 = 0;
      mi1 = 1'b0;
    end else begin
      if (lc1 >= 1 && lc1 <= 10) fr1 = {fr1[8:0], mo1};
      if (lc1 == 10) begin
        if (fr1[9:8] == 2'b00 || fr1[9:8] == 2'b10) addr_m = fr1[7:0];
        else if (fr1[9:8] == 2'b01) mem[addr_m] = fr1[7:0];
        else reply1 = fixed ? 8'hC3 : mem[addr_m];
      end
      mi1 = (lc1 >= 14 && lc1 < 22) ? reply1[21-lc1] : 1'b0;
      lc1++;
    end
  end
  // dut2 sees a fixed 8'hC3 one idle cycle after its last MOSI bit
  always @(negedge clk) begin
    mi2 = (ss2 === 1'b0 && lc2 >= 12 && lc2 < 20) ? pat2[19-lc2] : 1'b0;
    lc2 = (ss2 === 1'b0) ? lc2 + 1 : 0;
  end
  always @(negedge clk) if (rv1 === 1'b1) rv_cnt++;

  logic [10:0] mosi_q [$];
  logic [7:0]  rd_q [$];
  logic [10:0] obs_bits, eb;
  logic [7:0]  obs_rd, er;
  logic        obs_busy;
  bit          obs_ok;
  int          obs_wait, obs_n, obs_low, obs_hi, obs_nrv;

  task automatic issue(input bit sel, input logic [1:0] c, input logic [7:0] b);
    obs_ok = 0;
    obs_wait = 0;
    while (!obs_ok && obs_wait < 60) begin
      if ((sel ? r2 : r1) === 1'b1) obs_ok = 1;
      else begin obs_wait++; @(negedge clk); end
    end
    if (obs_ok) begin
      cmd = c;
      byt = b;
      if (sel) v2 = 1'b1; else v1 = 1'b1;
      @(posedge clk);
      #1;
      v1 = 1'b0;
      v2 = 1'b0;
    end
  endtask

  // records one frame from the cycle after the fire up to the first cycle ready returns
  task automatic collect(input bit sel);
    obs_n = 0; obs_low = 0; obs_hi = 0; obs_bits = '0; obs_nrv = 0; obs_rd = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if ((sel ? ss2 : ss1) === 1'b0) begin
        if (obs_low < 11) obs_bits = {obs_bits[9:0], sel ? mo2 : mo1};
        obs_low++;
      end else obs_hi++;
      if ((sel ? rv2 : rv1) === 1'b1) begin obs_nrv++; obs_rd = sel ? rd2 : rd1; end
      if ((sel ? r2 : r1) === 1'b1) begin obs_n = k - 1; break; end
    end
  endtask

  task automatic frame(input bit sel, input logic [1:0] c, input logic [7:0] b);
    mosi_q.push_back({c[1], c, c == 2'b11 ? 8'h00 : b});
    issue(sel, c, b);
    obs_busy = sel ? b2 : b1;
    collect(sel);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({r1, ss1, b1} !== 3'b010) begin n_bad++; $display("FAIL reset_hold {ready,ss_n,busy} got=%b exp=010", {r1, ss1, b1}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if ({ss1, mo1, r1, b1, rv1, rd1} !== {5'b10100, 8'h00}) begin n_bad++; $display("FAIL reset_idle {ss_n,mosi,ready,busy,rd_valid,rd_data} got=%b exp=%b", {ss1, mo1, r1, b1, rv1, rd1}, {5'b10100, 8'h00}); end
    n_cmp++; if ({ss2, r2, b2, rv2} !== 4'b1100) begin n_bad++; $display("FAIL reset_idle2 got=%b exp=1100", {ss2, r2, b2, rv2}); end
  endtask

  task automatic test_write();
    frame(0, 2'b00, 8'hA5);
    eb = mosi_q.pop_front();
    n_cmp++; if (!obs_ok || obs_busy !== 1'b1) begin n_bad++; $display("FAIL wr_accept ok=%0d busy=%b exp ok=1 busy=1", obs_ok, obs_busy); end
    n_cmp++; if (obs_bits !== eb) begin n_bad++; $display("FAIL wr_mosi got=%b exp=%b", obs_bits, eb); end
    n_cmp++; if (obs_low != 11) begin n_bad++; $display("FAIL wr_low got=%0d exp=11", obs_low); end
    n_cmp++; if (obs_n != 12) begin n_bad++; $display("FAIL wr_ready_latency got=%0d exp=12", obs_n); end
    n_cmp++; if (obs_hi != 2) begin n_bad++; $display("FAIL wr_gap_plus_idle got=%0d exp=2", obs_hi); end
    n_cmp++; if ({b1, mo1, ss1, rv1} !== 4'b0010) begin n_bad++; $display("FAIL wr_end got=%b exp=0010", {b1, mo1, ss1, rv1}); end
  endtask

  task automatic test_back_to_back();
    frame(0, 2'b01, 8'h3C);
    eb = mosi_q.pop_front();
    n_cmp++; if (obs_bits !== eb || obs_n != 12) begin n_bad++; $display("FAIL b2b_first bits=%b n=%0d exp bits=%b n=12", obs_bits, obs_n, eb); end
    n_cmp++; if (obs_hi != 2) begin n_bad++; $display("FAIL b2b_high_between got=%0d exp=2", obs_hi); end
    frame(0, 2'b10, 8'hA5);
    eb = mosi_q.pop_front();
    n_cmp++; if (obs_wait != 0) begin n_bad++; $display("FAIL b2b_first_idle_fire waited=%0d exp=0", obs_wait); end
    n_cmp++; if (obs_bits !== eb) begin n_bad++; $display("FAIL b2b_second_mosi got=%b exp=%b", obs_bits, eb); end
    n_cmp++; if (obs_n != 12 || obs_low != 11) begin n_bad++; $display("FAIL b2b_second_len n=%0d low=%0d exp 12/11", obs_n, obs_low); end
  endtask

  task automatic test_read_mem();
    logic [9:0] seq [3];
    seq = '{10'h0A5, 10'h15A, 10'h2A5};
    foreach (seq[i]) begin
      frame(0, seq[i][9:8], seq[i][7:0]);
      eb = mosi_q.pop_front();
      n_cmp++; if (obs_bits !== eb || obs_nrv != 0) begin n_bad++; $display("FAIL setup_frame%0d bits=%b nrv=%0d exp bits=%b nrv=0", i, obs_bits, obs_nrv, eb); end
    end
    rd_q.push_back(8'h5A);
    frame(0, 2'b11, 8'h77);
    eb = mosi_q.pop_front();
    er = rd_q.pop_front();
    n_cmp++; if (obs_bits !== eb) begin n_bad++; $display("FAIL rd_mosi got=%b exp=%b", obs_bits, eb); end
    n_cmp++; if (obs_low != 22 || obs_n != 23) begin n_bad++; $display("FAIL rd_len low=%0d n=%0d exp 22/23", obs_low, obs_n); end
    n_cmp++; if (obs_nrv != 1) begin n_bad++; $display("FAIL rd_valid_pulses got=%0d exp=1", obs_nrv); end
    n_cmp++; if (obs_rd !== er) begin n_bad++; $display("FAIL rd_data got=%h exp=%h", obs_rd, er); end
    frame(0, 2'b00, 8'h01);
    void'(mosi_q.pop_front());
    n_cmp++; if (rd1 !== 8'h5A || obs_nrv != 0) begin n_bad++; $display("FAIL rd_hold rd_data=%h nrv=%0d exp 5a/0", rd1, obs_nrv); end
  endtask

  task automatic test_fixed_miso();
    fixed = 1;
    rd_q.push_back(8'hC3);
    frame(0, 2'b11, 8'hFF);
    eb = mosi_q.pop_front();
    er = rd_q.pop_front();
    n_cmp++; if (obs_bits !== eb) begin n_bad++; $display("FAIL c3_mosi got=%b exp=%b", obs_bits, eb); end
    n_cmp++; if (obs_rd !== er || obs_nrv != 1 || obs_n != 23) begin n_bad++; $display("FAIL c3_d3 rd=%h nrv=%0d n=%0d exp %h/1/23", obs_rd, obs_nrv, obs_n, er); end
    rd_q.push_back(8'hC3);
    frame(1, 2'b11, 8'h00);
    eb = mosi_q.pop_front();
    er = rd_q.pop_front();
    n_cmp++; if (obs_bits !== eb) begin n_bad++; $display("FAIL c3_d1_mosi got=%b exp=%b", obs_bits, eb); end
    n_cmp++; if (obs_n != 21 || obs_low != 20) begin n_bad++; $display("FAIL c3_d1_len n=%0d low=%0d exp 21/20", obs_n, obs_low); end
    n_cmp++; if (obs_rd !== er || obs_nrv != 1) begin n_bad++; $display("FAIL c3_d1_data rd=%h nrv=%0d exp %h/1", obs_rd, obs_nrv, er); end
  endtask

  task automatic test_rst_mid();
    int rvc;
    issue(0, 2'b00, 8'h66);
    repeat (6) @(negedge clk);
    n_cmp++; if ({ss1, mo1} !== 2'b01) begin n_bad++; $display("FAIL rst_shift_pre {ss_n,mosi} got=%b exp=01", {ss1, mo1}); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ss1, mo1, r1, b1, rv1, rd1} !== {5'b10000, 8'h00}) begin n_bad++; $display("FAIL rst_shift got=%b exp=%b", {ss1, mo1, r1, b1, rv1, rd1}, {5'b10000, 8'h00}); end
    rst = 1'b0;
    rd_q.push_back(8'hC3);
    frame(0, 2'b11, 8'h00);
    void'(mosi_q.pop_front());
    er = rd_q.pop_front();
    n_cmp++; if (obs_rd !== er || obs_n != 23) begin n_bad++; $display("FAIL rst_shift_recover rd=%h n=%0d exp %h/23", obs_rd, obs_n, er); end
    rvc = rv_cnt;
    issue(0, 2'b11, 8'h00);
    repeat (20) @(negedge clk);
    n_cmp++; if ({ss1, b1, rv1} !== 3'b010) begin n_bad++; $display("FAIL rst_cap_pre {ss_n,busy,rd_valid} got=%b exp=010", {ss1, b1, rv1}); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ss1, mo1, rv1, rd1} !== {3'b100, 8'h00}) begin n_bad++; $display("FAIL rst_cap got=%b exp=%b", {ss1, mo1, rv1, rd1}, {3'b100, 8'h00}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rv_cnt != rvc || rd1 !== 8'h00) begin n_bad++; $display("FAIL rst_cap_discard pulses=%0d rd=%h exp %0d/00", rv_cnt, rd1, rvc); end
    rd_q.push_back(8'hC3);
    frame(0, 2'b11, 8'h00);
    void'(mosi_q.pop_front());
    er = rd_q.pop_front();
    n_cmp++; if (obs_rd !== er || obs_nrv != 1 || obs_n != 23) begin n_bad++; $display("FAIL rst_cap_recover rd=%h nrv=%0d n=%0d exp %h/1/23", obs_rd, obs_nrv, obs_n, er); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_read_mem();
    test_fixed_miso();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
